int_regwrite_port_arbiter: RTL and testbench
============================================

// Module: int_regwrite_port_arbiter
// PURPOSE
// - Shares NUM_PORT integer register-file write ports among NUM_REQ producer pipelines
//   (integer, complex-integer, memory), placed just ahead of the register-write stage.
// - Each requester owns a small in-order buffer; a round-robin scheduler drains buffer heads to the ports.
// - Buffered ops caught by a selective flush range are discarded and never written.
// PARAMETERS
// - NUM_REQ       3   producer pipelines
// - NUM_PORT      2   register-file write ports
// - QUEUE_DEPTH   2   entries per requester buffer (power of 2)
// - REG_NUM_WIDTH 7   physical destination register number width
// - DATA_WIDTH    33  write data width (data bits plus valid bit)
// - AL_PTR_WIDTH  6   active-list pointer width
// PORTS
// - clk            in   1                        clock
// - rst            in   1                        async reset, active-high
// - stall          in   1                        back-end stall: no grants, no dequeue
// - flush_valid    in   1                        selective flush this cycle
// - flush_head_ptr in   AL_PTR_WIDTH             flush range start (inclusive)
// - flush_tail_ptr in   AL_PTR_WIDTH             flush range end (exclusive)
// - req_valid      in   NUM_REQ                  per-requester write request
// - req_ready      out  NUM_REQ                  requester buffer can accept
// - req_reg_num    in   NUM_REQ*REG_NUM_WIDTH    destination physical register
// - req_data       in   NUM_REQ*DATA_WIDTH       write data
// - req_al_ptr     in   NUM_REQ*AL_PTR_WIDTH     active-list pointer of the op
// - wr_en          out  NUM_PORT                 register-file write enable
// - wr_reg_num     out  NUM_PORT*REG_NUM_WIDTH   write register number
// - wr_data        out  NUM_PORT*DATA_WIDTH      write data
// - wr_al_ptr      out  NUM_PORT*AL_PTR_WIDTH    active-list pointer, for completion marking
// - wr_src         out  NUM_PORT*$clog2(NUM_REQ) index of the granted requester
// BEHAVIOUR
// - Reset: all buffers empty, rr_ptr=0. Outputs: wr_en=0, req_ready=all 1,
//   wr_reg_num/wr_data/wr_al_ptr/wr_src=0.
// - Enqueue: when req_valid[i] && req_ready[i], push into buffer i. req_ready[i] = (count_i < QUEUE_DEPTH).
//   req_ready depends on the current count only; a full buffer is not ready even if it pops this cycle.
// - Latency: an op enqueued in cycle N is earliest at wr_* in cycle N+1. There is no same-cycle bypass.
// - Grant: only buffer heads are eligible. A head is eligible if its buffer is non-empty and it is not flushed.
//   - Scan requesters from rr_ptr upward, modulo NUM_REQ; grant the first NUM_PORT eligible heads.
//   - Grants fill port 0 first. At most one grant per requester per cycle.
//   - wr_* are combinational from the granted heads.
// - Pop: a granted head dequeues at the clock edge.
//   - rr_ptr <= (last granted index + 1) mod NUM_REQ.
//   - If nothing is granted, rr_ptr holds.
// - stall=1: wr_en=0, no pops, rr_ptr holds. Enqueue is still allowed while req_ready.
// - Flush range test (circular):
//   - head<tail: in = (ptr>=head && ptr<tail).
//   - head>tail: in = (ptr>=head || ptr<tail).
//   - head==tail: range is empty.
// - flush_valid=1: every buffered entry in range is invalidated at the edge.
//   - A flushed head is not granted in that same cycle.
//   - An incoming request in range is not enqueued, but still counts as accepted (ready unchanged).
//   - Flush applies regardless of stall.
// - Invalidated entries are compacted out or skipped. Remaining entries keep their order; counts drop accordingly.
// - Pointers wrap modulo QUEUE_DEPTH. Simultaneous push and pop on a non-full buffer keeps count unchanged.
// - Async reset mid-operation discards all buffered ops. The first grant after reset starts at requester 0.
// STRUCTURE
// - Shared package: WriteReqEntry struct {regNum, data, alPtr}, RegWriteArbReqIndex typedef,
//   and the circular-range flush function.
// - Sub-module: regwrite_req_buffer (one per requester): depth-QUEUE_DEPTH FIFO with per-entry flush invalidation.
// - Top level holds the round-robin grant logic, rr_ptr register and port muxing.
// TESTING
// - Reset, then one req0 push (reg 5, data 0x1234, al 3) -> cycle+1: wr_en=01, wr_reg_num[0]=5, wr_src[0]=0; req_ready all 1.
// - All 3 requesters push every cycle, no stall -> 2 writes/cycle, grant order rotates (0,1),(2,0),(1,2); each req_ready drops when full.
// - Buffer 1 full (2 entries) and stall=1 for 3 cycles -> wr_en=0, req_ready[1]=0, no loss; after release, entries exit in order.
// - flush head=4 tail=8, buffered al ptrs 3,5,9 -> only 5 is dropped; 3 and 9 are still written. Head 60, tail 2 (wrap) drops 62 and 1.
// - Flush asserted while req2 pushes al 6 (range 4..8) -> op never appears on wr_*, count unchanged.
// - Assert rst with 4 ops buffered -> next cycle wr_en=0, req_ready all 1, rr_ptr=0.

Source files
------------

// File: rtl/int_regwrite_port_arbiter_pkg.sv
// Shared types, sizes and the circular flush-range test for the register-write port arbiter.
package int_regwrite_port_arbiter_pkg;

  localparam int unsigned NUM_REQ       = 3;
  localparam int unsigned NUM_PORT      = 2;
  localparam int unsigned QUEUE_DEPTH   = 2;
  localparam int unsigned REG_NUM_WIDTH = 7;
  localparam int unsigned DATA_WIDTH    = 33;
  localparam int unsigned AL_PTR_WIDTH  = 6;
  localparam int unsigned REQ_IDX_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH     = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [REG_NUM_WIDTH-1:0] reg_num;
    logic [DATA_WIDTH-1:0]    data;
    logic [AL_PTR_WIDTH-1:0]  al_ptr;
  } write_req_entry_t;

  typedef logic [REQ_IDX_WIDTH-1:0] req_index_t;

  // Range is [head, tail) on the circular active list; head == tail means empty.
  function automatic logic in_flush_range(input logic [AL_PTR_WIDTH-1:0] ptr,
                                          input logic [AL_PTR_WIDTH-1:0] head,
                                          input logic [AL_PTR_WIDTH-1:0] tail);
    logic hit;
    if (head < tail) begin
      hit = (ptr >= head) && (ptr < tail);
    end else if (head > tail) begin
      hit = (ptr >= head) || (ptr < tail);
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/int_regwrite_port_arbiter_req_buffer.sv
// Per-requester in-order buffer; flushed entries are compacted out so index 0 is always the head.
module regwrite_req_buffer
  import int_regwrite_port_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_valid,
  input  logic [AL_PTR_WIDTH-1:0] flush_head_ptr,
  input  logic [AL_PTR_WIDTH-1:0] flush_tail_ptr,
  input  logic                    push_valid,
  input  write_req_entry_t        push_entry,
  input  logic                    pop,
  output logic                    ready,
  output logic                    head_valid,
  output write_req_entry_t        head_entry
);

  write_req_entry_t     entries_q [QUEUE_DEPTH];
  write_req_entry_t     entries_d [QUEUE_DEPTH];
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 keep;

  assign ready      = (count_q < CNT_WIDTH'(QUEUE_DEPTH));
  assign head_entry = entries_q[0];
  assign head_valid = (count_q != '0) &&
                      !(flush_valid && in_flush_range(entries_q[0].al_ptr, flush_head_ptr, flush_tail_ptr));

  // Survivors (not popped, not flushed) slide down in order, then the accepted push is appended.
  always_comb begin
    count_d = '0;
    keep    = 1'b0;
    for (int j = 0; j < int'(QUEUE_DEPTH); j++) entries_d[j] = '0;
    for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
      keep = (CNT_WIDTH'(i) < count_q) && !(pop && (i == 0)) &&
             !(flush_valid && in_flush_range(entries_q[i].al_ptr, flush_head_ptr, flush_tail_ptr));
      if (keep) begin
        for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
          if (CNT_WIDTH'(j) == count_d) entries_d[j] = entries_q[i];
        end
        count_d = count_d + CNT_WIDTH'(1);
      end
    end
    keep = push_valid && ready &&
           !(flush_valid && in_flush_range(push_entry.al_ptr, flush_head_ptr, flush_tail_ptr));
    if (keep) begin
      for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
        if (CNT_WIDTH'(j) == count_d) entries_d[j] = push_entry;
      end
      count_d = count_d + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int j = 0; j < int'(QUEUE_DEPTH); j++) entries_q[j] <= '0;
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/int_regwrite_port_arbiter.sv
// Round-robin sharing of the integer register-file write ports among buffered producer pipelines.
module int_regwrite_port_arbiter
  import int_regwrite_port_arbiter_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic                              flush_valid,
  input  logic [AL_PTR_WIDTH-1:0]           flush_head_ptr,
  input  logic [AL_PTR_WIDTH-1:0]           flush_tail_ptr,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*REG_NUM_WIDTH-1:0]  req_reg_num,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ*AL_PTR_WIDTH-1:0]   req_al_ptr,
  output logic [NUM_PORT-1:0]               wr_en,
  output logic [NUM_PORT*REG_NUM_WIDTH-1:0] wr_reg_num,
  output logic [NUM_PORT*DATA_WIDTH-1:0]    wr_data,
  output logic [NUM_PORT*AL_PTR_WIDTH-1:0]  wr_al_ptr,
  output logic [NUM_PORT*REQ_IDX_WIDTH-1:0] wr_src
);

  write_req_entry_t   head_entry [NUM_REQ];
  logic [NUM_REQ-1:0] head_valid;
  logic [NUM_REQ-1:0] grant;
  req_index_t         rr_ptr_q;
  req_index_t         rr_ptr_d;
  int                 idx;
  int                 n_grant;

  for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_buf
    write_req_entry_t push_entry;
    assign push_entry = {req_reg_num[g*REG_NUM_WIDTH +: REG_NUM_WIDTH],
                         req_data[g*DATA_WIDTH +: DATA_WIDTH],
                         req_al_ptr[g*AL_PTR_WIDTH +: AL_PTR_WIDTH]};

    regwrite_req_buffer u_buf (
      .clk            (clk),
      .rst            (rst),
      .flush_valid    (flush_valid),
      .flush_head_ptr (flush_head_ptr),
      .flush_tail_ptr (flush_tail_ptr),
      .push_valid     (req_valid[g]),
      .push_entry     (push_entry),
      .pop            (grant[g]),
      .ready          (req_ready[g]),
      .head_valid     (head_valid[g]),
      .head_entry     (head_entry[g])
    );
  end

  // Scan from rr_ptr, filling ports in order with the first eligible heads.
  always_comb begin
    grant      = '0;
    wr_en      = '0;
    wr_reg_num = '0;
    wr_data    = '0;
    wr_al_ptr  = '0;
    wr_src     = '0;
    rr_ptr_d   = rr_ptr_q;
    n_grant    = 0;
    idx        = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
      if (!stall && head_valid[idx] && (n_grant < int'(NUM_PORT))) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < int'(NUM_PORT); p++) begin
          if (p == n_grant) begin
            wr_en[p]                                      = 1'b1;
            wr_reg_num[p*REG_NUM_WIDTH +: REG_NUM_WIDTH]  = head_entry[idx].reg_num;
            wr_data[p*DATA_WIDTH +: DATA_WIDTH]           = head_entry[idx].data;
            wr_al_ptr[p*AL_PTR_WIDTH +: AL_PTR_WIDTH]     = head_entry[idx].al_ptr;
            wr_src[p*REQ_IDX_WIDTH +: REQ_IDX_WIDTH]      = req_index_t'(idx);
          end
        end
        n_grant  = n_grant + 1;
        rr_ptr_d = req_index_t'((idx + 1) % int'(NUM_REQ));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_int_regwrite_port_arbiter.sv
// Randomized and directed checks of the write-port arbiter against a queue-based reference model.
module tb_int_regwrite_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush_valid;
  logic [5:0]  flush_head_ptr;
  logic [5:0]  flush_tail_ptr;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [20:0] req_reg_num;
  logic [98:0] req_data;
  logic [17:0] req_al_ptr;
  logic [1:0]  wr_en;
  logic [13:0] wr_reg_num;
  logic [65:0] wr_data;
  logic [11:0] wr_al_ptr;
  logic [3:0]  wr_src;

  logic [6:0]  rn [3];
  logic [32:0] dt [3];
  logic [5:0]  ap [3];

  typedef struct {
    logic [6:0]  r;
    logic [32:0] d;
    logic [5:0]  a;
  } ent_t;

  ent_t q [3][$];
  int   rr;
  int   n_checks = 0;
  int   n_errors = 0;

  assign req_reg_num = {rn[2], rn[1], rn[0]};
  assign req_data    = {dt[2], dt[1], dt[0]};
  assign req_al_ptr  = {ap[2], ap[1], ap[0]};

  always #5 clk = ~clk;

  int_regwrite_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush_valid    (flush_valid),
    .flush_head_ptr (flush_head_ptr),
    .flush_tail_ptr (flush_tail_ptr),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_reg_num    (req_reg_num),
    .req_data       (req_data),
    .req_al_ptr     (req_al_ptr),
    .wr_en          (wr_en),
    .wr_reg_num     (wr_reg_num),
    .wr_data        (wr_data),
    .wr_al_ptr      (wr_al_ptr),
    .wr_src         (wr_src)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Distance from head along the circular list must be shorter than the range length.
  function automatic bit in_rng(input logic [5:0] p, input logic [5:0] h, input logic [5:0] t);
    int dp;
    int dt_len;
    dp     = (int'(p) - int'(h) + 64) % 64;
    dt_len = (int'(t) - int'(h) + 64) % 64;
    return dp < dt_len;
  endfunction

  task automatic idle_inputs();
    req_valid   = '0;
    stall       = 1'b0;
    flush_valid = 1'b0;
    flush_head_ptr = '0;
    flush_tail_ptr = '0;
    for (int i = 0; i < 3; i++) begin
      rn[i] = '0; dt[i] = '0; ap[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] r, input logic [32:0] d, input logic [5:0] a);
    req_valid[i] = 1'b1;
    rn[i] = r; dt[i] = d; ap[i] = a;
  endtask

  // Compare this cycle's outputs with the model, advance the model, move to just after the next edge.
  task automatic step();
    logic [2:0] rdy;
    logic [2:0] elig;
    logic [1:0] exp_en;
    int         gnt[$];
    ent_t       keep[$];
    ent_t       e;
    #3;
    for (int i = 0; i < 3; i++) begin
      rdy[i]  = (q[i].size() < 2);
      elig[i] = (q[i].size() > 0) && !(flush_valid && in_rng(q[i][0].a, flush_head_ptr, flush_tail_ptr));
    end
    if (!stall) begin
      for (int k = 0; k < 3; k++) begin
        if (elig[(rr + k) % 3] && gnt.size() < 2) gnt.push_back((rr + k) % 3);
      end
    end
    exp_en = (gnt.size() == 0) ? 2'b00 : (gnt.size() == 1) ? 2'b01 : 2'b11;
    chk("req_ready", 64'(req_ready), 64'(rdy));
    chk("wr_en", 64'(wr_en), 64'(exp_en));
    for (int p = 0; p < gnt.size(); p++) begin
      e = q[gnt[p]][0];
      chk("wr_src", 64'(wr_src[p*2 +: 2]), 64'(gnt[p]));
      chk("wr_reg_num", 64'(wr_reg_num[p*7 +: 7]), 64'(e.r));
      chk("wr_data", 64'(wr_data[p*33 +: 33]), 64'(e.d));
      chk("wr_al_ptr", 64'(wr_al_ptr[p*6 +: 6]), 64'(e.a));
    end
    if (gnt.size() > 0) rr = (gnt[gnt.size()-1] + 1) % 3;
    foreach (gnt[p]) void'(q[gnt[p]].pop_front());
    if (flush_valid) begin
      for (int i = 0; i < 3; i++) begin
        keep = {};
        foreach (q[i][j]) if (!in_rng(q[i][j].a, flush_head_ptr, flush_tail_ptr)) keep.push_back(q[i][j]);
        q[i] = keep;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && rdy[i] && !(flush_valid && in_rng(ap[i], flush_head_ptr, flush_tail_ptr))) begin
        e.r = rn[i]; e.d = dt[i]; e.a = ap[i];
        q[i].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) q[i] = {};
    rr = 0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'b111);
    chk("rst_wr_reg_num", 64'(wr_reg_num), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_wr_al_ptr", 64'(wr_al_ptr), 64'd0);
    chk("rst_wr_src", 64'(wr_src), 64'd0);
    rst = 1'b0;

    // Single push appears one cycle later on port 0.
    set_req(0, 7'd5, 33'h1234, 6'd3);
    step();
    idle_inputs();
    #2;
    chk("s1_wr_en", 64'(wr_en), 64'b01);
    chk("s1_reg", 64'(wr_reg_num[6:0]), 64'd5);
    chk("s1_src", 64'(wr_src[1:0]), 64'd0);
    chk("s1_ready", 64'(req_ready), 64'b111);
    step();
    drain();

    // All requesters push every cycle; grants rotate.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, 7'($urandom), {1'($urandom), 32'($urandom)}, 6'($urandom));
      step();
    end
    drain();

    // Fill buffer 1 under stall, hold the stall, then release.
    stall = 1'b1;
    set_req(1, 7'd10, 33'h111, 6'd20);
    step();
    set_req(1, 7'd11, 33'h222, 6'd21);
    step();
    idle_inputs();
    stall = 1'b1;
    repeat (3) step();
    drain();

    // Flush 4..8 with buffered al ptrs 3,5,9.
    stall = 1'b1;
    set_req(0, 7'd30, 33'h3, 6'd3);
    set_req(1, 7'd31, 33'h9, 6'd9);
    step();
    idle_inputs();
    stall = 1'b1;
    set_req(0, 7'd32, 33'h5, 6'd5);
    step();
    idle_inputs();
    stall = 1'b1;
    flush_valid = 1'b1; flush_head_ptr = 6'd4; flush_tail_ptr = 6'd8;
    step();
    drain();

    // Wrapping flush 60..2 drops 62 and 1, keeps 30.
    stall = 1'b1;
    set_req(0, 7'd40, 33'h62, 6'd62);
    set_req(1, 7'd41, 33'h1, 6'd1);
    set_req(2, 7'd42, 33'h30, 6'd30);
    step();
    idle_inputs();
    stall = 1'b1;
    flush_valid = 1'b1; flush_head_ptr = 6'd60; flush_tail_ptr = 6'd2;
    step();
    drain();

    // Incoming op inside the flush range is swallowed.
    set_req(2, 7'd50, 33'h6, 6'd6);
    flush_valid = 1'b1; flush_head_ptr = 6'd4; flush_tail_ptr = 6'd8;
    step();
    drain();

    // Async reset with four ops buffered.
    stall = 1'b1;
    set_req(0, 7'd60, 33'hA, 6'd10);
    set_req(1, 7'd61, 33'hB, 6'd11);
    step();
    step();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'b111);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 7'(i + 1), 33'(i + 100), 6'(i + 40));
    step();
    idle_inputs();
    #2;
    chk("arst_first_src0", 64'(wr_src[1:0]), 64'd0);
    chk("arst_first_src1", 64'(wr_src[3:2]), 64'd1);
    step();
    drain();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        req_valid[i] = 1'($urandom);
        rn[i] = 7'($urandom);
        dt[i] = {1'($urandom), 32'($urandom)};
        ap[i] = 6'($urandom);
      end
      stall          = ($urandom % 5) == 0;
      flush_valid    = ($urandom % 4) == 0;
      flush_head_ptr = 6'($urandom);
      flush_tail_ptr = 6'($urandom);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
